// File: rtl/rr_encoder16.sv
// Round-robin priority encoder: picks one of 16 requests starting from a rotating
// priority pointer and holds the registered grant under a valid/ready handshake.
module rr_encoder16 #(
  parameter int unsigned PTR_RESET = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] req,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [3:0]  out_idx,
  output logic [15:0] out_oh
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] oh_q, oh_d;
  logic [3:0]  ptr_q, ptr_d;

  logic [3:0]  search_base;
  logic [3:0]  pos;
  logic [3:0]  pick;
  logic        any_req;

  assign any_req = |req;

  // On an accept the search must already start after the granted entry, before
  // ptr_q has been updated, so the base is taken from the held index.
  always_comb begin
    search_base = (state_q == HOLD) ? idx_q + 4'd1 : ptr_q;
    pick        = '0;
    pos         = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      pos = search_base + 4'(15 - i);
      if (req[pos]) begin
        pick = pos;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (!flush && any_req) begin
          idx_d   = pick;
          oh_d    = 16'h0001 << pick;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (flush) begin
          state_d = IDLE;
          oh_d    = '0;
        end else if (out_ready) begin
          ptr_d = idx_q + 4'd1;
          if (any_req) begin
            idx_d = pick;
            oh_d  = 16'h0001 << pick;
          end else begin
            state_d = IDLE;
            oh_d    = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        oh_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      oh_q    <= '0;
      ptr_q   <= 4'(PTR_RESET);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_idx   = idx_q;
  assign out_oh    = oh_q;

endmodule
